// File: rtl/spike_event_fifo.sv
// ---------------------------------------------------------------------------
// spike_event_fifo
//
// Purpose:
//   Sits behind the delta comparator. On every sample strobe it samples the
//   2-bit spike code; events are stamped with the sample-index timestamp
//   counter and queued in a small FIFO. The head of the queue is presented on
//   a registered valid/ready port (first-word fall-through, one cycle after
//   the push edge) to the output pin serializer. Events that arrive while the
//   FIFO is full and nothing is leaving are dropped and reported through a
//   sticky overflow flag.
//
// Ports:
//   clk         in   system clock, all state changes on the rising edge
//   rst         in   synchronous active-high reset, highest priority
//   sample_en   in   one-cycle strobe qualifying spike
//   spike       in   [0]=event present, [1]=polarity (1=OFF, 0=ON)
//   ovf_clr     in   clears the sticky overflow flag
//   out_ready   in   consumer accepts out_data this cycle
//   out_valid   out  head entry is valid (registered)
//   out_data    out  {polarity, timestamp} of the head entry, 0 when empty
//   fifo_count  out  number of occupied entries
//   overflow    out  sticky flag, set when an event was dropped
//
// Parameters:
//   TS_WIDTH    timestamp counter width, wraps at 2**TS_WIDTH
//   DEPTH       FIFO depth, power of two, at least 2
// ---------------------------------------------------------------------------
module spike_event_fifo #(
  parameter int TS_WIDTH = 6,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic [1:0]               spike,
  input  logic                     ovf_clr,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [TS_WIDTH:0]        out_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = TS_WIDTH + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [TS_WIDTH-1:0] TS_ONE = TS_WIDTH'(1);

  // Registered state
  logic [TS_WIDTH-1:0] ts_q,        ts_d;
  logic [PTR_W-1:0]    wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0]    count_q,     count_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q,  out_data_d;
  logic                overflow_q,  overflow_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  // Per-cycle handshake decode
  logic                push;
  logic                pop;
  logic                full;
  logic                accept;
  logic                drop;
  logic [DATA_W-1:0]   push_word;

  // Decode push/pop for this cycle. A push into a full FIFO is only accepted
  // when the head is leaving on the same edge, because the popped slot is the
  // one the write pointer is aiming at.
  always_comb begin
    push      = sample_en & spike[0];
    pop       = out_valid_q & out_ready;
    full      = (count_q == CNT_FULL);
    accept    = push & (~full | pop);
    drop      = push & full & ~pop;
    push_word = {spike[1], ts_q};
  end

  // Timestamp advances on every strobe regardless of whether an event is
  // present; the stamp taken by a push is the pre-increment value.
  always_comb begin
    ts_d = ts_q;
    if (sample_en) begin
      ts_d = ts_q + TS_ONE;
    end
  end

  // Storage and pointer update. Full/empty are never derived from the
  // pointers, only from the occupancy count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accept) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Occupancy: simultaneous accept and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (accept && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !accept) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Registered output stage. The head is looked up in the post-update
  // storage, so a word written into an empty FIFO shows up on the very next
  // cycle and an unpopped head stays put while the consumer stalls.
  always_comb begin
    out_valid_d = (count_d != '0);
    out_data_d  = '0;
    if (count_d != '0) begin
      out_data_d = mem_d[rd_ptr_d];
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear leaves it set.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // State register with synchronous reset; reset discards every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ts_q        <= ts_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_spike_event_fifo.sv
// ---------------------------------------------------------------------------
// tb_spike_event_fifo
//
// Purpose:
//   Self-checking bench for spike_event_fifo (TS_WIDTH=6, DEPTH=4). Applies a
//   table of directed vectors, hand-written corner sequences (overflow, full
//   push+pop, timestamp wrap, reset with queued entries, clear vs drop) and a
//   randomized run compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_spike_event_fifo;

  localparam int TS_WIDTH = 6;
  localparam int DEPTH    = 4;
  localparam int TS_MOD   = 1 << TS_WIDTH;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [1:0] spike;
  logic       ovf_clr;
  logic       out_ready;
  logic       out_valid;
  logic [6:0] out_data;
  logic [2:0] fifo_count;
  logic       overflow;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a queue of pending words, an integer sample index and
  // a sticky drop flag.
  logic [6:0] model_q[$];
  int         model_ts  = 0;
  logic       model_ovf = 1'b0;

  typedef struct {
    logic       rst;
    logic       se;
    logic [1:0] spike;
    logic       clr;
    logic       rdy;
    logic       exp_valid;
    logic [6:0] exp_data;
    logic [2:0] exp_count;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[13];

  spike_event_fifo #(
    .TS_WIDTH(TS_WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_en(sample_en),
    .spike(spike),
    .ovf_clr(ovf_clr),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Advance the reference model by one clock edge using the inputs that the
  // DUT is about to sample.
  task automatic modelStep(input logic r, input logic se, input logic [1:0] sp,
                           input logic clr, input logic rdy);
    logic was_valid;
    logic was_full;
    logic do_pop;
    if (r) begin
      model_q.delete();
      model_ts  = 0;
      model_ovf = 1'b0;
    end else begin
      was_valid = (model_q.size() != 0);
      was_full  = (model_q.size() == DEPTH);
      do_pop    = was_valid && rdy;
      if (do_pop) begin
        void'(model_q.pop_front());
      end
      if (se && sp[0]) begin
        if (was_full && !do_pop) begin
          model_ovf = 1'b1;
        end else begin
          model_q.push_back({sp[1], 6'(model_ts)});
        end
      end else if (clr) begin
        model_ovf = 1'b0;
      end
      if (se && sp[0] && !(was_full && !do_pop)) begin
        if (clr) model_ovf = model_ovf;
      end
      if (clr && !(se && sp[0] && was_full && !do_pop)) begin
        model_ovf = 1'b0;
      end
      if (se) begin
        model_ts = (model_ts + 1) % TS_MOD;
      end
    end
  endtask

  // Drive one cycle of inputs, let the clock edge happen, then settle
  task automatic applyStimulus(input logic r, input logic se, input logic [1:0] sp,
                               input logic clr, input logic rdy);
    rst       = r;
    sample_en = se;
    spike     = sp;
    ovf_clr   = clr;
    out_ready = rdy;
    modelStep(r, se, sp, clr, rdy);
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs against one expected tuple
  task automatic checkOutput(input string name, input logic ev, input logic [6:0] ed,
                             input logic [2:0] ec, input logic eo);
    vectors++;
    if (out_valid !== ev || out_data !== ed || fifo_count !== ec || overflow !== eo) begin
      miscompares++;
      $display("[TB] FAIL %s: got valid=%b data=%h count=%0d ovf=%b, expected valid=%b data=%h count=%0d ovf=%b",
               name, out_valid, out_data, fifo_count, overflow, ev, ed, ec, eo);
    end
  endtask

  // Compare outputs against the reference model's view of the queue
  task automatic checkModel(input string name);
    logic [6:0] head;
    head = (model_q.size() != 0) ? model_q[0] : 7'h00;
    checkOutput(name, model_q.size() != 0, head, 3'(model_q.size()), model_ovf);
  endtask

  initial begin
    // rst se spike clr rdy | valid data count ovf
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 7'h00, 3'd1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 7'h00, 3'd1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 7'h00, 3'd2, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 7'h42, 3'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 7'h00, 3'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 7'h04, 3'd1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 7'h00, 3'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 7'h00, 3'd0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 7'h05, 3'd1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 7'h00, 3'd0, 1'b0};

    rst = 1'b1; sample_en = 1'b0; spike = 2'b00; ovf_clr = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    // Directed table: basic stamping, no-event polarity, gated strobe
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].se, vecs[i].spike, vecs[i].clr, vecs[i].rdy);
      checkOutput($sformatf("table[%0d]", i), vecs[i].exp_valid, vecs[i].exp_data,
                  vecs[i].exp_count, vecs[i].exp_ovf);
    end

    // Five pushes with a stalled consumer: the fifth is dropped
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    checkOutput("fill4", 1'b1, 7'h00, 3'd4, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    checkOutput("drop5", 1'b1, 7'h00, 3'd4, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("drain1", 1'b1, 7'h01, 3'd3, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("drain2", 1'b1, 7'h02, 3'd2, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("drain3", 1'b1, 7'h03, 3'd1, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("drain4", 1'b0, 7'h00, 3'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("ovf_clear", 1'b0, 7'h00, 3'd0, 1'b0);

    // Full FIFO with push and pop on the same edge
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
    checkOutput("full_pushpop", 1'b1, 7'h01, 3'd4, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("fp_drain1", 1'b1, 7'h02, 3'd3, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("fp_drain2", 1'b1, 7'h03, 3'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("fp_drain3", 1'b1, 7'h44, 3'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("fp_empty", 1'b0, 7'h00, 3'd0, 1'b0);

    // Timestamp wrap: stamp 63, then the next strobe is stamped 0
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 63; i++) applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
    checkOutput("ts63", 1'b1, 7'h7F, 3'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    checkOutput("ts_wrap_push", 1'b1, 7'h7F, 3'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("ts_wrap_head", 1'b1, 7'h00, 3'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("ts_wrap_empty", 1'b0, 7'h00, 3'd0, 1'b0);

    // Reset with entries queued wins over a concurrent push
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    checkOutput("three_queued", 1'b1, 7'h00, 3'd3, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    checkOutput("reset_discard", 1'b0, 7'h00, 3'd0, 1'b0);

    // Clear in the same cycle as a drop leaves overflow set
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    checkOutput("ovf_set", 1'b1, 7'h00, 3'd4, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, 1'b0);
    checkOutput("clr_vs_drop", 1'b1, 7'h00, 3'd4, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("clr_alone", 1'b1, 7'h00, 3'd4, 1'b0);

    // Randomized traffic against the reference model
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    checkModel("rand_reset");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 2) == 0));
      checkModel($sformatf("rand[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
